// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the memory bus arbiter.
// Round-robin selection is compiled in with MEM_ARB_RR_EN; fixed priority otherwise.
package mem_bus_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        RDATA,
        WDATA,
        WRESP
    } mem_arb_state_t;

    localparam int MEM_ARB_REQ_NUM = 3;

    localparam int ARB_UNCACHED = 0;
    localparam int ARB_DCACHE   = 1;
    localparam int ARB_ICACHE   = 2;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_arb_select.sv
// Winner selection: lowest index wins, or a rotating search from the pointer
// when MEM_ARB_RR_EN is defined.
module arb_select
    import mem_bus_arbiter_pkg::*;
#(
    parameter int N_REQ = MEM_ARB_REQ_NUM,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    output logic [N_REQ-1:0] win_oh,
    output logic [IDX_W-1:0] win_idx
);

`ifdef MEM_ARB_RR_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             found;
    int               k;

    // Pointer holds the index just after the last completed owner.
    always_comb begin
        ptr_d = ptr_q;
        if (upd_en) ptr_d = IDX_W'(wrap_inc(int'(upd_idx), N_REQ));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ptr_q <= '0;
        else      ptr_q <= ptr_d;
    end

    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        found   = 1'b0;
        k       = 0;
        for (int i = 0; i < N_REQ; i++) begin
            k = (int'(ptr_q) + i) % N_REQ;
            if (!found && req[IDX_W'(k)]) begin
                found                = 1'b1;
                win_oh[IDX_W'(k)]    = 1'b1;
                win_idx              = IDX_W'(k);
            end
        end
    end
`else
    logic unused_ok;
    assign unused_ok = ^{clk, rst, upd_en, upd_idx};

    // Scan downward so the lowest requesting index is the last one written.
    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_oh  = '0;
                win_oh[i] = 1'b1;
                win_idx = IDX_W'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one burst memory port among N_REQ masters, one transaction at a time.
// Define MEM_ARB_RR_EN for round-robin arbitration instead of fixed priority.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int N_REQ      = MEM_ARB_REQ_NUM,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [N_REQ-1:0]                     s_req,
    input  logic [N_REQ-1:0]                     s_we,
    input  logic [N_REQ-1:0][ADDR_WIDTH-1:0]     s_addr,
    input  logic [N_REQ-1:0][LEN_WIDTH-1:0]      s_len,
    input  logic [N_REQ-1:0][DATA_WIDTH-1:0]     s_wdata,
    input  logic [N_REQ-1:0]                     s_wvalid,
    output logic [N_REQ-1:0]                     s_wready,
    output logic [N_REQ-1:0]                     s_gnt,
    output logic [N_REQ-1:0]                     s_rvalid,
    output logic [DATA_WIDTH-1:0]                s_rdata,
    output logic                                 s_rlast,
    output logic [N_REQ-1:0]                     s_done,
    output logic                                 m_req,
    output logic                                 m_we,
    output logic [ADDR_WIDTH-1:0]                m_addr,
    output logic [LEN_WIDTH-1:0]                 m_len,
    input  logic                                 m_ack,
    output logic [DATA_WIDTH-1:0]                m_wdata,
    output logic                                 m_wvalid,
    output logic                                 m_wlast,
    input  logic                                 m_wready,
    input  logic                                 m_rvalid,
    input  logic                                 m_rlast,
    input  logic [DATA_WIDTH-1:0]                m_rdata,
    input  logic                                 m_bvalid
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    mem_arb_state_t          state_q, state_d;
    logic [IDX_W-1:0]        owner_q, owner_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [LEN_WIDTH-1:0]    len_q, len_d;
    logic [LEN_WIDTH-1:0]    cnt_q, cnt_d;
    logic [N_REQ-1:0]        gnt_q, gnt_d;
    logic [N_REQ-1:0]        done_q, done_d;

    logic [N_REQ-1:0]        win_oh;
    logic [IDX_W-1:0]        win_idx;

    arb_select #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb_select (
        .clk     (clk),
        .rst     (rst),
        .req     (s_req),
        .upd_en  (|done_d),
        .upd_idx (owner_q),
        .win_oh  (win_oh),
        .win_idx (win_idx)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        gnt_d   = '0;
        done_d  = '0;
        case (state_q)
            IDLE: begin
                if (|win_oh) begin
                    owner_d = win_idx;
                    we_d    = s_we[win_idx];
                    addr_d  = s_addr[win_idx];
                    len_d   = s_len[win_idx];
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (m_ack) begin
                    gnt_d[owner_q] = 1'b1;
                    cnt_d          = '0;
                    state_d        = we_q ? WDATA : RDATA;
                end
            end
            RDATA: begin
                // An early rlast still ends the burst; the slave owns the length.
                if (m_rvalid && m_rlast) begin
                    done_d[owner_q] = 1'b1;
                    state_d         = IDLE;
                end
            end
            WDATA: begin
                if (m_wvalid && m_wready) begin
                    if (cnt_q == len_q) state_d = WRESP;
                    else                cnt_d   = cnt_q + LEN_WIDTH'(1);
                end
            end
            WRESP: begin
                if (m_bvalid) begin
                    done_d[owner_q] = 1'b1;
                    state_d         = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
        end
    end

    assign m_req  = (state_q == ADDR);
    assign m_we   = we_q;
    assign m_addr = addr_q;
    assign m_len  = len_q;
    assign s_gnt  = gnt_q;
    assign s_done = done_q;

    // Beat routing only for the current owner; everyone else sees zeros.
    always_comb begin
        s_rvalid = '0;
        s_rdata  = '0;
        s_rlast  = 1'b0;
        s_wready = '0;
        m_wdata  = '0;
        m_wvalid = 1'b0;
        m_wlast  = 1'b0;
        if (state_q == RDATA) begin
            s_rvalid[owner_q] = m_rvalid;
            s_rdata           = m_rdata;
            s_rlast           = m_rlast;
        end
        if (state_q == WDATA) begin
            m_wdata           = s_wdata[owner_q];
            m_wvalid          = s_wvalid[owner_q];
            m_wlast           = (cnt_q == len_q);
            s_wready[owner_q] = m_wready;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: table vectors, contention against a
// reference arbitration model, early rlast, mid-transaction reset, long bursts.
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 4;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic [N-1:0]           s_req, s_we, s_wvalid, s_wready, s_gnt, s_rvalid, s_done;
    logic [N-1:0][AW-1:0]   s_addr;
    logic [N-1:0][LW-1:0]   s_len;
    logic [N-1:0][DW-1:0]   s_wdata;
    logic [DW-1:0]          s_rdata, m_wdata, m_rdata;
    logic                   s_rlast, m_req, m_we, m_ack, m_wvalid, m_wlast;
    logic                   m_wready, m_rvalid, m_rlast, m_bvalid;
    logic [AW-1:0]          m_addr;
    logic [LW-1:0]          m_len;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)
    ) dut (
        .clk(clk), .rst(rst),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_len(s_len),
        .s_wdata(s_wdata), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rlast(s_rlast),
        .s_done(s_done),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_len(m_len), .m_ack(m_ack),
        .m_wdata(m_wdata), .m_wvalid(m_wvalid), .m_wlast(m_wlast), .m_wready(m_wready),
        .m_rvalid(m_rvalid), .m_rlast(m_rlast), .m_rdata(m_rdata), .m_bvalid(m_bvalid)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    // Reference model: pending requests with their fields, plus the RR pointer.
    logic          p_we   [N];
    logic [AW-1:0] p_addr [N];
    logic [LW-1:0] p_len  [N];
    logic [DW-1:0] p_wbase[N];
    bit            pending[N];
`ifdef MEM_ARB_RR_EN
    int            rr_ptr = 0;
`endif

    typedef struct {
        int           idx;
        logic         we;
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        logic [DW-1:0] wbase;
        logic [N-1:0] exp_gnt;
        int           exp_beats;
    } vec_t;
    vec_t tv[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_pick();
        int start;
        start = 0;
`ifdef MEM_ARB_RR_EN
        start = rr_ptr;
`endif
        for (int i = 0; i < N; i++)
            if (pending[(start + i) % N]) return (start + i) % N;
        return -1;
    endfunction

    task automatic model_done(input int idx);
`ifdef MEM_ARB_RR_EN
        rr_ptr = (idx + 1) % N;
`else
        if (idx < 0) $display("bad index");
`endif
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) pending[i] = 1'b0;
`ifdef MEM_ARB_RR_EN
        rr_ptr = 0;
`endif
    endtask

    task automatic raise(input int idx, input logic we, input logic [AW-1:0] a,
                         input logic [LW-1:0] l, input logic [DW-1:0] wb);
        p_we[idx] = we; p_addr[idx] = a; p_len[idx] = l; p_wbase[idx] = wb;
        pending[idx] = 1'b1;
        s_req[idx] = 1'b1; s_we[idx] = we; s_addr[idx] = a; s_len[idx] = l;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_ctl"}, {m_req, m_we, m_wvalid, m_wlast, s_rlast, s_gnt, s_done,
                             s_rvalid, s_wready, m_len}, 64'd0);
        chk({name, "_addr"}, m_addr, 64'd0);
        chk({name, "_data"}, {m_wdata, s_rdata}, 64'd0);
    endtask

    // Runs one owner's transaction from its address phase through s_done.
    // Entered and left at negedge+1; nb is the number of beats the slave gives.
    task automatic serve_one(input int idx, input logic [N-1:0] oh, input int nb,
                             input int mid_raise);
        int t, b;
        logic [DW-1:0] d;
        logic v, r;
        t = 0;
        while (m_req !== 1'b1 && t < 8) begin @(negedge clk); #1; t++; end
        chk("addr_phase", m_req, 1);
        chk("m_addr", m_addr, p_addr[idx]);
        chk("m_len", m_len, p_len[idx]);
        chk("m_we", m_we, p_we[idx]);
        repeat ($urandom_range(0, 2)) begin
            @(negedge clk); #1;
            chk("m_req_hold", m_req, 1);
            chk("s_gnt_early", s_gnt, 0);
        end
        @(negedge clk); m_ack = 1'b1; #1;
        @(negedge clk); m_ack = 1'b0; s_req[idx] = 1'b0; pending[idx] = 1'b0; #1;
        chk("s_gnt", s_gnt, oh);
        chk("m_req_drop", m_req, 0);
        if (mid_raise >= 0)
            raise(mid_raise, 1'($urandom_range(0, 1)), $urandom, LW'($urandom_range(0, 3)), $urandom);
        b = 0; t = 0;
        if (!p_we[idx]) begin
            while (b < nb && t < 200) begin
                @(negedge clk); t++;
                if ($urandom_range(0, 3) == 0) begin
                    m_rvalid = 1'b0; m_rlast = 1'b0; #1;
                    chk("s_rvalid_idle", s_rvalid, 0);
                end else begin
                    d = $urandom;
                    m_rvalid = 1'b1; m_rdata = d; m_rlast = (b == nb - 1); #1;
                    chk("s_rvalid", s_rvalid, oh);
                    chk("s_rdata", s_rdata, d);
                    chk("s_rlast", s_rlast, (b == nb - 1));
                    b++;
                end
            end
            chk("read_beats", b, nb);
            @(negedge clk); m_rvalid = 1'b0; m_rlast = 1'b0; #1;
            chk("s_done_rd", s_done, oh);
            chk("s_rvalid_after", s_rvalid, 0);
        end else begin
            while (b < nb && t < 400) begin
                @(negedge clk); t++;
                v = ($urandom_range(0, 3) != 0);
                r = 1'($urandom_range(0, 1));
                d = b[0] ? ~p_wbase[idx] : p_wbase[idx];
                s_wvalid[idx] = v; s_wdata[idx] = d; m_wready = r; #1;
                chk("m_wvalid", m_wvalid, v);
                chk("m_wdata", m_wdata, d);
                chk("m_wlast", m_wlast, (b == nb - 1));
                chk("s_wready", s_wready, r ? oh : '0);
                if (v && r) b++;
            end
            chk("write_beats", b, nb);
            // A further offered beat must not reach the port once the burst is done.
            @(negedge clk); s_wvalid[idx] = 1'b1; m_wready = 1'b1; #1;
            chk("m_wvalid_resp", m_wvalid, 0);
            chk("s_wready_resp", s_wready, 0);
            s_wvalid[idx] = 1'b0; m_wready = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk); #1;
                chk("s_done_early", s_done, 0);
            end
            @(negedge clk); m_bvalid = 1'b1; #1;
            chk("s_done_pre_b", s_done, 0);
            @(negedge clk); m_bvalid = 1'b0; #1;
            chk("s_done_wr", s_done, oh);
        end
        model_done(idx);
    endtask

    task automatic serve_model(input int mid_raise);
        int w;
        w = model_pick();
        if (w < 0) begin
            chk("model_nothing_pending", 0, 1);
        end else begin
            serve_one(w, N'(1 << w), int'(p_len[w]) + 1, (mid_raise == w) ? -1 : mid_raise);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int guard;
        tv[0] = '{ARB_ICACHE,   1'b0, 32'h1FC0_0000, 4'd3,  32'h0,         3'b100, 4};
        tv[1] = '{ARB_DCACHE,   1'b1, 32'h8000_1000, 4'd1,  32'hA5A5_A5A5, 3'b010, 2};
        tv[2] = '{ARB_UNCACHED, 1'b0, 32'h0000_0040, 4'd0,  32'h0,         3'b001, 1};
        tv[3] = '{ARB_DCACHE,   1'b1, 32'h8000_2000, 4'd15, 32'h1234_5678, 3'b010, 16};
        tv[4] = '{ARB_UNCACHED, 1'b1, 32'hBFD0_0010, 4'd0,  32'hDEAD_BEEF, 3'b001, 1};
        tv[5] = '{ARB_ICACHE,   1'b0, 32'h1FC0_0100, 4'd15, 32'h0,         3'b100, 16};

        s_req = '0; s_we = '0; s_addr = '0; s_len = '0; s_wdata = '0; s_wvalid = '0;
        m_ack = 0; m_wready = 0; m_rvalid = 0; m_rlast = 0; m_rdata = '0; m_bvalid = 0;
        model_reset();

        #12;
        chk_all_zero("reset_state");
        @(negedge clk); rst = 1'b1; #1;

        // Single transactions from the table; also checks the IDLE->ADDR latency.
        for (int i = 0; i < 6; i++) begin
            raise(tv[i].idx, tv[i].we, tv[i].addr, tv[i].len, tv[i].wbase);
            chk("m_req_same_cycle", m_req, 0);
            @(negedge clk); #1;
            chk("m_req_latency", m_req, 1);
            serve_one(tv[i].idx, tv[i].exp_gnt, tv[i].exp_beats, -1);
        end

        // Three-way contention; requester 0 re-requests during the second owner.
        for (int i = 0; i < N; i++)
            raise(i, 1'($urandom_range(0, 1)), $urandom, LW'($urandom_range(0, 3)), $urandom);
        serve_model(-1);
        serve_model(0);
        guard = 0;
        while (model_pick() >= 0 && guard < 6) begin serve_model(-1); guard++; end

        // All requests held high across six transactions.
        for (int i = 0; i < N; i++)
            raise(i, 1'b0, $urandom, LW'($urandom_range(0, 2)), $urandom);
        for (int k = 0; k < 6; k++) begin
            int w;
            w = model_pick();
            serve_model(-1);
            if (w >= 0) raise(w, 1'b0, $urandom, LW'($urandom_range(0, 2)), $urandom);
        end
        guard = 0;
        while (model_pick() >= 0 && guard < 6) begin serve_model(-1); guard++; end

        // Random arrivals.
        for (int k = 0; k < 14; k++) begin
            for (int i = 0; i < N; i++)
                if (!pending[i] && $urandom_range(0, 1) == 1)
                    raise(i, 1'($urandom_range(0, 1)), $urandom, LW'($urandom_range(0, 4)), $urandom);
            if (model_pick() >= 0) serve_model(-1);
            else begin @(negedge clk); #1; chk("idle_no_req", m_req, 0); end
        end
        guard = 0;
        while (model_pick() >= 0 && guard < 6) begin serve_model(-1); guard++; end

        // Slave ends a len-7 read after 3 beats.
        raise(ARB_ICACHE, 1'b0, 32'h1FC0_0200, 4'd7, 32'h0);
        @(negedge clk); #1;
        serve_one(ARB_ICACHE, 3'b100, 3, -1);

        // Asynchronous reset during beat 2 of a len-7 read.
        raise(ARB_UNCACHED, 1'b0, 32'h2000_0000, 4'd7, 32'h0);
        @(negedge clk); #1;
        chk("rst_seq_m_req", m_req, 1);
        @(negedge clk); m_ack = 1'b1; #1;
        @(negedge clk); m_ack = 1'b0; s_req[0] = 1'b0; pending[0] = 1'b0; #1;
        @(negedge clk); m_rvalid = 1'b1; m_rdata = 32'h1111_1111; m_rlast = 1'b0; #1;
        @(negedge clk); m_rdata = 32'h2222_2222; #1;
        chk("rst_seq_beat2", s_rvalid, 3'b001);
        #1 rst = 1'b0; #1;
        chk_all_zero("async_reset");
        m_rvalid = 1'b0; m_rdata = '0;
        model_reset();
        @(negedge clk); rst = 1'b1; #1;
        raise(ARB_DCACHE, 1'b0, 32'h3000_0000, 4'd1, 32'h0);
        chk("post_rst_m_req0", m_req, 0);
        @(negedge clk); #1;
        chk("post_rst_m_req1", m_req, 1);
        serve_one(ARB_DCACHE, 3'b010, 2, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
